afifo_wr_arbiter: RTL and testbench

AFIFO_WR_ARBITER -- requirements
Module: afifo_wr_arbiter

---
 rtl/afifo_wr_arbiter_if.sv | 31 +++
 rtl/afifo_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_afifo_wr_arbiter.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_wr_arbiter_if.sv
// Purpose : bundles the requester-side and FIFO-side signals of the write arbiter.
// Latency : n/a (wiring only).
// Backpressure: full travels toward the arbiter; gnt/ack/winc travel away from it.
// Ports   : req/req_data/full into the arbiter; gnt/ack/winc/writeData/busy/wr_count out of it.
`timescale 1ns/1ps
interface afifo_wr_arbiter_if #(
   parameter int NREQ = 4,
   parameter int DW   = 8
);
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_data;
   logic               full;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    ack;
   logic               winc;
   logic [DW-1:0]      writeData;
   logic               busy;
   logic [15:0]        wr_count;

   // master: the requesters plus the FIFO full flag (testbench side)
   modport master (
      output req, req_data, full,
      input  gnt, ack, winc, writeData, busy, wr_count
   );

   // slave: the arbiter itself
   modport slave (
      input  req, req_data, full,
      output gnt, ack, winc, writeData, busy, wr_count
   );
endinterface

// File: rtl/afifo_wr_arbiter.sv
// Purpose : round-robin arbiter sharing one async-FIFO write port among NREQ requesters, bursts of up to MAX_BURST words.
// Latency : grant 1 cycle after req; winc/ack/writeData combinational from the current grant.
// Backpressure: full=1 stalls the current burst indefinitely (grant held, burst count frozen).
// Ports   : wclk, wrst_n (async active-low); bus = afifo_wr_arbiter_if.slave (req, req_data, full in;
//           gnt, ack, winc, writeData, busy, wr_count out).
`timescale 1ns/1ps
module afifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                   wclk,
   input  logic                   wrst_n,
   afifo_wr_arbiter_if.slave      bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_nxt;
   logic [IW-1:0]   owner, owner_nxt;
   logic [IW-1:0]   last, last_nxt;
   logic [3:0]      burst_cnt, burst_nxt;
   logic [NREQ-1:0] gnt, gnt_nxt;
   logic [15:0]     wr_count;
   logic            w;
   logic            grant_end;
   logic [IW:0]     pick_idle;
   logic [IW:0]     pick_other;
   logic [DW-1:0]   data_sel;

   // Cyclic search starting at from+1 and wrapping through from itself.
   // Returns {found, index}; iterating from the far end lets the nearest hit win.
   function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] from);
      logic [IW:0] res;
      int          j;
      res = '0;
      for (int k = NREQ; k >= 1; k--) begin
         j = (int'(from) + k) % NREQ;
         if (r[j[IW-1:0]]) res = {1'b1, j[IW-1:0]};
      end
      return res;
   endfunction

   always_comb begin
      data_sel = bus.req_data[DW-1:0];
      for (int i = 0; i < NREQ; i++) begin
         if (owner == IW'(i)) data_sel = bus.req_data[i*DW +: DW];
      end
   end

   always_comb begin
      w          = (state == GRANT) && bus.req[owner] && !bus.full;
      state_nxt  = state;
      owner_nxt  = owner;
      last_nxt   = last;
      burst_nxt  = burst_cnt;
      gnt_nxt    = gnt;
      pick_idle  = rr_pick(bus.req, last);
      // the current owner is masked out so a hand-off only goes to someone else
      pick_other = rr_pick(bus.req & ~(NREQ'(1) << owner), owner);
      grant_end  = !bus.req[owner] || (w && (burst_cnt == 4'(MAX_BURST - 1)));

      case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (pick_idle[IW]) begin
               state_nxt = GRANT;
               owner_nxt = pick_idle[IW-1:0];
               burst_nxt = '0;
               gnt_nxt   = NREQ'(1) << pick_idle[IW-1:0];
            end
         end
         GRANT: begin
            if (w) burst_nxt = burst_cnt + 4'd1;
            if (grant_end) begin
               last_nxt  = owner;
               burst_nxt = '0;
               if (pick_other[IW]) begin
                  // direct hand-off, no idle bubble between owners
                  owner_nxt = pick_other[IW-1:0];
                  gnt_nxt   = NREQ'(1) << pick_other[IW-1:0];
               end else begin
                  // a still-requesting owner at burst limit is re-granted from IDLE
                  state_nxt = IDLE;
                  gnt_nxt   = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state     <= IDLE;
         owner     <= '0;
         last      <= IW'(NREQ - 1);   // requester 0 wins the first arbitration
         burst_cnt <= '0;
         gnt       <= '0;
      end else begin
         state     <= state_nxt;
         owner     <= owner_nxt;
         last      <= last_nxt;
         burst_cnt <= burst_nxt;
         gnt       <= gnt_nxt;
      end
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) wr_count <= '0;
      else if (w)  wr_count <= wr_count + 16'd1;
   end

   assign bus.gnt       = gnt;
   assign bus.ack       = w ? (NREQ'(1) << owner) : '0;
   assign bus.winc      = w;
   assign bus.writeData = data_sel;
   assign bus.busy      = (state == GRANT);
   assign bus.wr_count  = wr_count;
endmodule

// File: tb/tb_afifo_wr_arbiter.sv
// Purpose : self-checking bench for afifo_wr_arbiter; cycle-level reference model plus scenario checks.
// Latency : n/a.
// Backpressure: full is driven directly by the bench, both scripted and random.
`timescale 1ns/1ps
module tb_afifo_wr_arbiter;
   localparam int NREQ      = 4;
   localparam int DW        = 8;
   localparam int MAX_BURST = 4;

   logic wclk = 1'b0;
   logic wrst_n;

   afifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

   afifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .bus    (bus.slave)
   );

   always #5 wclk = ~wclk;

   int checks   = 0;
   int failures = 0;

   // requester stimulus state
   int            pend [NREQ];
   logic [DW-1:0] dat  [NREQ];
   logic          wd   [NREQ];
   logic          full_r;

   // reference model
   bit m_busy;
   int m_owner, m_last, m_burst, m_cnt;

   // writes as seen on the DUT outputs
   int            log_owner[$];
   logic [DW-1:0] log_data[$];
   int            log_cyc[$];
   bit            log_en;
   int            nwrites;
   int            cyc;

   function automatic int rr_next(int from, logic [NREQ-1:0] mask);
      for (int k = 1; k <= NREQ; k++) begin
         if (mask[(from + k) % NREQ]) return (from + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 0;
      m_last  = NREQ - 1;
      m_burst = 0;
      m_cnt   = 0;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         bus.req[i]                = (pend[i] > 0) && !wd[i];
         bus.req_data[i*DW +: DW]  = dat[i];
      end
      bus.full = full_r;
   endtask

   task automatic clear_log();
      log_owner.delete();
      log_data.delete();
      log_cyc.delete();
      nwrites = 0;
      log_en  = 1'b1;
   endtask

   task automatic do_reset();
      wrst_n = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 0;
         wd[i]   = 1'b0;
      end
      full_r = 1'b0;
      drive();
      model_reset();
      repeat (2) @(posedge wclk);
      #1;
      wrst_n = 1'b1;
   endtask

   // One clock: compare DUT against the model at the falling edge, advance the model,
   // then let requesters react to the acks once the rising edge has passed.
   task automatic step();
      logic            e_w;
      logic [NREQ-1:0] e_gnt, e_ack, others;
      logic            g_end;
      int              widx, down;
      @(negedge wclk);
      e_w   = m_busy && bus.req[m_owner] && !bus.full;
      e_gnt = m_busy ? (NREQ'(1) << m_owner) : '0;
      e_ack = e_w ? e_gnt : '0;

      checks++;
      if (bus.gnt !== e_gnt) begin
         failures++; $display("FAIL gnt cyc=%0d got=%b exp=%b", cyc, bus.gnt, e_gnt);
      end
      checks++;
      if (bus.ack !== e_ack) begin
         failures++; $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, bus.ack, e_ack);
      end
      checks++;
      if (bus.winc !== e_w) begin
         failures++; $display("FAIL winc cyc=%0d got=%b exp=%b", cyc, bus.winc, e_w);
      end
      checks++;
      if (bus.busy !== m_busy) begin
         failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, m_busy);
      end
      if (m_busy) begin
         checks++;
         if (bus.writeData !== dat[m_owner]) begin
            failures++; $display("FAIL wdata cyc=%0d got=%h exp=%h", cyc, bus.writeData, dat[m_owner]);
         end
      end
      checks++;
      if ((bus.winc & bus.full) !== 1'b0) begin
         failures++; $display("FAIL winc_while_full cyc=%0d got=1 exp=0", cyc);
      end
      checks++;
      if ((bus.ack & ~bus.gnt) !== '0) begin
         failures++; $display("FAIL ack_without_gnt cyc=%0d ack=%b gnt=%b", cyc, bus.ack, bus.gnt);
      end

      if (bus.winc === 1'b1) begin
         down = -1;
         for (int i = 0; i < NREQ; i++) if (bus.ack[i] === 1'b1) down = i;
         nwrites++;
         if (log_en) begin
            log_owner.push_back(down);
            log_data.push_back(bus.writeData);
            log_cyc.push_back(cyc);
         end
      end

      widx = -1;
      if (!m_busy) begin
         if (bus.req != '0) begin
            m_owner = rr_next(m_last, bus.req);
            m_busy  = 1'b1;
            m_burst = 0;
         end
      end else begin
         g_end = !bus.req[m_owner] || (e_w && m_burst == MAX_BURST - 1);
         if (e_w) begin
            widx = m_owner;
            m_burst++;
            m_cnt = (m_cnt + 1) % 65536;
         end
         if (g_end) begin
            m_last  = m_owner;
            m_burst = 0;
            others  = bus.req;
            others[m_owner] = 1'b0;
            if (others != '0) m_owner = rr_next(m_owner, others);
            else              m_busy  = 1'b0;
         end
      end

      @(posedge wclk);
      #1;
      cyc++;
      if (widx >= 0) begin
         pend[widx]--;
         dat[widx]++;
      end
      drive();
      checks++;
      if (bus.wr_count !== 16'(m_cnt)) begin
         failures++; $display("FAIL wr_count cyc=%0d got=%0d exp=%0d", cyc, bus.wr_count, m_cnt);
      end
   endtask

   task automatic run_writes(int target, int budget, string name);
      int n;
      n = 0;
      while (nwrites < target && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (nwrites < target) begin
         failures++; $display("FAIL %s timeout writes=%0d need=%0d", name, nwrites, target);
      end
   endtask

   task automatic idle_out();
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 0;
         wd[i]   = 1'b0;
      end
      full_r = 1'b0;
      drive();
      repeat (3) step();
   endtask

   task automatic test_reset();
      wrst_n = 1'b0;
      model_reset();
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 1;
         wd[i]   = 1'b0;
         dat[i]  = DW'($urandom);
      end
      full_r = 1'b0;
      drive();
      #2;
      checks++; if (bus.gnt !== '0)       begin failures++; $display("FAIL rst_gnt got=%b exp=0", bus.gnt); end
      checks++; if (bus.ack !== '0)       begin failures++; $display("FAIL rst_ack got=%b exp=0", bus.ack); end
      checks++; if (bus.winc !== 1'b0)    begin failures++; $display("FAIL rst_winc got=%b exp=0", bus.winc); end
      checks++; if (bus.busy !== 1'b0)    begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.wr_count !== '0)  begin failures++; $display("FAIL rst_wr_count got=%0d exp=0", bus.wr_count); end
      @(posedge wclk);
      #1;
      checks++; if (bus.gnt !== '0)       begin failures++; $display("FAIL rst_edge_gnt got=%b exp=0", bus.gnt); end
      do_reset();
   endtask

   task automatic test_single();
      logic [DW-1:0] exp_d [3];
      exp_d = '{8'h12, 8'h13, 8'h14};
      do_reset();
      clear_log();
      pend[2] = 3;
      dat[2]  = 8'h12;
      drive();
      step();
      checks++;
      if (bus.gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", bus.gnt); end
      run_writes(3, 10, "single");
      repeat (3) step();
      checks++;
      if (log_owner.size() != 3) begin failures++; $display("FAIL single_count got=%0d exp=3", log_owner.size()); end
      for (int k = 0; k < 3 && k < log_owner.size(); k++) begin
         checks++;
         if (log_owner[k] != 2 || log_data[k] !== exp_d[k]) begin
            failures++; $display("FAIL single_word%0d got=%0d/%h exp=2/%h", k, log_owner[k], log_data[k], exp_d[k]);
         end
      end
      checks++;
      if (log_cyc.size() == 3 && log_cyc[2] - log_cyc[0] != 2) begin
         failures++; $display("FAIL single_consecutive span=%0d exp=2", log_cyc[2] - log_cyc[0]);
      end
      checks++; if (bus.wr_count !== 16'd3) begin failures++; $display("FAIL single_wr_count got=%0d exp=3", bus.wr_count); end
      checks++; if (bus.busy !== 1'b0)      begin failures++; $display("FAIL single_idle got=%b exp=0", bus.busy); end
   endtask

   task automatic test_all_rotate();
      do_reset();
      clear_log();
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 100;
         dat[i]  = DW'(8'h40 * i);
      end
      drive();
      run_writes(20, 40, "rotate");
      for (int k = 0; k < 20 && k < log_owner.size(); k++) begin
         checks++;
         if (log_owner[k] != (k / MAX_BURST) % NREQ) begin
            failures++; $display("FAIL rotate_owner%0d got=%0d exp=%0d", k, log_owner[k], (k / MAX_BURST) % NREQ);
         end
      end
      checks++;
      if (log_cyc.size() >= 20 && log_cyc[19] - log_cyc[0] != 19) begin
         failures++; $display("FAIL rotate_no_bubble span=%0d exp=19", log_cyc[19] - log_cyc[0]);
      end
      idle_out();
   endtask

   task automatic test_full_stall();
      int exp_o [8];
      exp_o = '{1, 1, 1, 1, 3, 3, 1, 1};
      do_reset();
      clear_log();
      pend[1] = 6;
      pend[3] = 2;
      drive();
      run_writes(2, 10, "stall_pre");
      full_r = 1'b1;
      drive();
      repeat (5) step();
      checks++; if (nwrites != 2)         begin failures++; $display("FAIL stall_writes got=%0d exp=2", nwrites); end
      checks++; if (bus.gnt !== 4'b0010)  begin failures++; $display("FAIL stall_gnt got=%b exp=0010", bus.gnt); end
      full_r = 1'b0;
      drive();
      run_writes(8, 30, "stall_post");
      for (int k = 0; k < 8 && k < log_owner.size(); k++) begin
         checks++;
         if (log_owner[k] != exp_o[k]) begin
            failures++; $display("FAIL stall_owner%0d got=%0d exp=%0d", k, log_owner[k], exp_o[k]);
         end
      end
      checks++;
      if (log_cyc.size() >= 3 && log_cyc[2] - log_cyc[1] != 6) begin
         failures++; $display("FAIL stall_gap got=%0d exp=6", log_cyc[2] - log_cyc[1]);
      end
      idle_out();
   endtask

   task automatic test_fairness();
      int exp_o [7];
      exp_o = '{3, 3, 3, 0, 0, 2, 2};
      do_reset();
      clear_log();
      pend[3] = 3;
      drive();
      run_writes(1, 10, "fair_pre");
      pend[0] = 2;
      pend[2] = 2;
      drive();
      run_writes(7, 30, "fair_post");
      for (int k = 0; k < 7 && k < log_owner.size(); k++) begin
         checks++;
         if (log_owner[k] != exp_o[k]) begin
            failures++; $display("FAIL fair_owner%0d got=%0d exp=%0d", k, log_owner[k], exp_o[k]);
         end
      end
      idle_out();
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      clear_log();
      pend[2] = 10;
      drive();
      run_writes(2, 10, "midrst_pre");
      wrst_n = 1'b0;
      #1;
      checks++; if (bus.gnt !== '0)      begin failures++; $display("FAIL midrst_gnt got=%b exp=0", bus.gnt); end
      checks++; if (bus.winc !== 1'b0)   begin failures++; $display("FAIL midrst_winc got=%b exp=0", bus.winc); end
      checks++; if (bus.ack !== '0)      begin failures++; $display("FAIL midrst_ack got=%b exp=0", bus.ack); end
      checks++; if (bus.wr_count !== '0) begin failures++; $display("FAIL midrst_wr_count got=%0d exp=0", bus.wr_count); end
      pend[1] = 3;
      drive();
      model_reset();
      #2;
      wrst_n = 1'b1;
      clear_log();
      run_writes(1, 10, "midrst_post");
      checks++;
      if (log_owner.size() < 1 || log_owner[0] != 1) begin
         failures++; $display("FAIL midrst_first_owner got=%0d exp=1", (log_owner.size() > 0) ? log_owner[0] : -1);
      end
      idle_out();
   endtask

   task automatic test_random();
      do_reset();
      clear_log();
      log_en = 1'b0;
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (pend[i] == 0 && $urandom_range(0, 3) == 0) begin
               pend[i] = $urandom_range(1, 6);
               dat[i]  = DW'($urandom);
            end
            if ($urandom_range(0, 7) == 0) wd[i] = !wd[i];
         end
         full_r = ($urandom_range(0, 3) == 0);
         drive();
         step();
      end
      idle_out();
   endtask

   task automatic test_wrap();
      do_reset();
      clear_log();
      log_en  = 1'b0;
      pend[0] = 100000;
      pend[1] = 100000;
      drive();
      run_writes(65535, 70000, "wrap_pre");
      checks++; if (bus.wr_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_ffff got=%h exp=ffff", bus.wr_count); end
      run_writes(65537, 10, "wrap_post");
      checks++; if (bus.wr_count !== 16'h0001) begin failures++; $display("FAIL wrap_one got=%h exp=0001", bus.wr_count); end
      idle_out();
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc    = 0;
      log_en = 1'b1;
      nwrites = 0;
      wrst_n = 1'b0;
      full_r = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 0;
         wd[i]   = 1'b0;
         dat[i]  = '0;
      end
      drive();
      test_reset();
      test_single();
      test_all_rotate();
      test_full_stall();
      test_fairness();
      test_reset_mid_burst();
      test_random();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
